// File: rtl/jtframe_obj_sched.sv
// Per-line object scheduler: scans the object table on each line start and
// issues one drawer request per visible entry. Option: JTFRAME_OBJ_LIMIT_EN caps hits per line.
module jtframe_obj_sched #(
  parameter int unsigned CW     = 12,
  parameter int unsigned PW     = 8,
  parameter int unsigned AW     = 7,
  parameter int unsigned MAXOBJ = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [8:0]            vrender,
  output logic [AW-1:0]         obj_addr,
  input  logic [CW+PW+16-1:0]   obj_data,
  output logic                  draw,
  input  logic                  dr_busy,
  output logic [CW-1:0]         code,
  output logic [8:0]            xpos,
  output logic [3:0]            ysub,
  output logic                  hflip,
  output logic                  vflip,
  output logic [PW-5:0]         pal,
  output logic                  done,
  output logic                  ovf
);

  localparam int unsigned DW = CW + PW + 16;
  localparam logic [AW-1:0] LAST = {AW{1'b1}};

  typedef enum logic [2:0] {IDLE, READ, WAIT, CHECK, ISSUE, HOLD, DONE} state_t;

  state_t        state;
  logic [AW-1:0] index;

  logic [8:0]    ent_y;
  logic [8:0]    ydiff;
  logic          hit;

  assign ent_y = obj_data[8:0];
  assign ydiff = vrender - ent_y;
  assign hit   = ydiff[8:4] == 5'd0;

`ifdef JTFRAME_OBJ_LIMIT_EN
  localparam int unsigned HW = $clog2(MAXOBJ + 1);
  logic [HW-1:0] hits;
  logic          limit;
  assign limit = hits == HW'(MAXOBJ);
`else
  assign ovf = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      index    <= '0;
      obj_addr <= '0;
      draw     <= 1'b0;
      done     <= 1'b1;
      code     <= '0;
      xpos     <= '0;
      ysub     <= '0;
      hflip    <= 1'b0;
      vflip    <= 1'b0;
      pal      <= '0;
`ifdef JTFRAME_OBJ_LIMIT_EN
      ovf      <= 1'b0;
      hits     <= '0;
`endif
    end else begin
      draw <= 1'b0;
      if (start) begin
        // a request being granted this cycle still goes out; the scan restarts
        if (state == ISSUE && !dr_busy) draw <= 1'b1;
        index <= '0;
        done  <= 1'b0;
        state <= READ;
`ifdef JTFRAME_OBJ_LIMIT_EN
        ovf   <= 1'b0;
        hits  <= '0;
`endif
      end else begin
        case (state)
          IDLE: ;
          READ: begin
            obj_addr <= index;
            state    <= WAIT;
          end
          WAIT: state <= CHECK;
          CHECK: begin
            if (ent_y == 9'h1FF) begin
              done  <= 1'b1;
              state <= DONE;
            end else if (hit) begin
`ifdef JTFRAME_OBJ_LIMIT_EN
              if (limit) begin
                ovf   <= 1'b1;
                done  <= 1'b1;
                state <= DONE;
              end else begin
`endif
                code  <= obj_data[DW-1:PW+16];
                pal   <= obj_data[PW+15:20];
                vflip <= obj_data[19];
                hflip <= obj_data[18];
                xpos  <= obj_data[17:9];
                ysub  <= ydiff[3:0];
                state <= ISSUE;
`ifdef JTFRAME_OBJ_LIMIT_EN
              end
`endif
            end else if (index == LAST) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              index <= index + AW'(1);
              state <= READ;
            end
          end
          ISSUE: begin
            if (!dr_busy) begin
              draw  <= 1'b1;
              state <= HOLD;
`ifdef JTFRAME_OBJ_LIMIT_EN
              hits  <= hits + HW'(1);
`endif
            end
          end
          HOLD: begin
            // dead cycle lets the drawer raise busy before the next grant
            if (index == LAST) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              index <= index + AW'(1);
              state <= READ;
            end
          end
          DONE: done <= 1'b1;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
